// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: FSM state codes,
// default widths and a small helper for the pass count.
package counter_sequencer_pkg;

   localparam int WIDTH_DEF  = 4;
   localparam int PASS_W_DEF = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_COUNT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // A request for zero traversals still runs one.
   function automatic logic [PASS_W_DEF-1:0] pass_min1(
      input logic [PASS_W_DEF-1:0] p
   );
      return (p == '0) ? PASS_W_DEF'(1) : p;
   endfunction

endpackage

// File: rtl/counter_4bit.sv
// Up/down counter datapath driven by counter_sequencer.
// Ports: Clk, Reset (sync, active-high), Load/Count_in, Count_en, Up -> Count_out.
module Counter_4bit (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Load,
   input  logic       Count_en,
   input  logic       Up,
   input  logic [3:0] Count_in,
   output logic [3:0] Count_out
);

   always_ff @(posedge Clk) begin
      if (Reset)
         Count_out <= 4'd0;
      else if (Load)
         Count_out <= Count_in;
      else if (Count_en)
         Count_out <= Up ? Count_out + 4'd1 : Count_out - 4'd1;
   end

endmodule

// File: rtl/counter_sequencer.sv
// Sequences one Counter_4bit: load start value, count to end value,
// optional ping-pong passes, then a one-cycle Done pulse.
// Inputs : Clk, Reset (sync, active-high), Start, Start_val, End_val,
//          Passes, Abort, Ctr_Count_out (counter feedback).
// Outputs: Ctr_Load, Ctr_Count_en, Ctr_Up, Ctr_Count_in, Busy, Done.
module counter_sequencer
   import counter_sequencer_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int PASS_W = PASS_W_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [WIDTH-1:0]  Start_val,
   input  logic [WIDTH-1:0]  End_val,
   input  logic [PASS_W-1:0] Passes,
   input  logic              Abort,
   input  logic [WIDTH-1:0]  Ctr_Count_out,
   output logic              Ctr_Load,
   output logic              Ctr_Count_en,
   output logic              Ctr_Up,
   output logic [WIDTH-1:0]  Ctr_Count_in,
   output logic              Busy,
   output logic              Done
);

   logic [1:0]        state;
   logic [WIDTH-1:0]  s_q;
   logic [WIDTH-1:0]  e_q;
   logic [PASS_W-1:0] pass_q;
   logic              up_q;
   logic              at_end;

   assign at_end = (Ctr_Count_out == e_q);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= ST_IDLE;
         s_q    <= '0;
         e_q    <= '0;
         pass_q <= '0;
         up_q   <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (Start && !Abort) begin
                  s_q    <= Start_val;
                  e_q    <= End_val;
                  pass_q <= (Passes == '0) ? PASS_W'(1) : Passes;
                  up_q   <= (End_val > Start_val);
                  state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               state <= Abort ? ST_IDLE : ST_COUNT;
            end
            ST_COUNT: begin
               if (Abort) begin
                  state <= ST_IDLE;
               end else if (at_end) begin
                  if (pass_q > PASS_W'(1)) begin
                     // Reverse: this equality cycle is the idle cycle.
                     s_q    <= e_q;
                     e_q    <= s_q;
                     up_q   <= ~up_q;
                     pass_q <= pass_q - PASS_W'(1);
                  end else begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Abort gates the counter controls in the same cycle so the
   // counter value observed when aborting is the one it keeps.
   always_comb begin
      Ctr_Load     = 1'b0;
      Ctr_Count_en = 1'b0;
      Ctr_Up       = 1'b0;
      Ctr_Count_in = '0;
      Busy         = 1'b0;
      Done         = 1'b0;
      unique case (state)
         ST_LOAD: begin
            Busy         = 1'b1;
            Ctr_Load     = ~Abort;
            Ctr_Count_in = s_q;
         end
         ST_COUNT: begin
            Busy         = 1'b1;
            Ctr_Up       = up_q;
            Ctr_Count_en = ~at_end & ~Abort;
         end
         ST_DONE: begin
            Done = 1'b1;
         end
         default: begin
            Busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench: counter_sequencer driving Counter_4bit, table-driven runs
// plus hand-written abort / reset / ignored-start sequences.
module tb_counter_sequencer;

   localparam int W  = 4;
   localparam int PW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  sval;
   logic [W-1:0]  eval;
   logic [PW-1:0] passes;
   logic          abort;
   logic [W-1:0]  count_out;
   logic          load;
   logic          en;
   logic          up;
   logic [W-1:0]  count_in;
   logic          busy;
   logic          done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   counter_sequencer #(.WIDTH(W), .PASS_W(PW)) dut (
      .Clk          (clk),
      .Reset        (rst),
      .Start        (start),
      .Start_val    (sval),
      .End_val      (eval),
      .Passes       (passes),
      .Abort        (abort),
      .Ctr_Count_out(count_out),
      .Ctr_Load     (load),
      .Ctr_Count_en (en),
      .Ctr_Up       (up),
      .Ctr_Count_in (count_in),
      .Busy         (busy),
      .Done         (done)
   );

   Counter_4bit ctr (
      .Clk      (clk),
      .Reset    (rst),
      .Load     (load),
      .Count_en (en),
      .Up       (up),
      .Count_in (count_in),
      .Count_out(count_out)
   );

   typedef struct {
      string name;
      int    sv;
      int    ev;
      int    np;
      bit    poke;
      int    exp_done;
      int    exp_en;
      int    exp_up;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int q[$];
      int cur, tgt, np;
      int done_c = -1;
      int fin = -1;
      int up_c2 = -1;
      int ndone = 0, nload = 0, nen = 0, errs = 0, viol = 0;
      np  = (v.np == 0) ? 1 : v.np;
      cur = v.sv;
      tgt = v.ev;
      q.push_back(cur);
      for (int p = 0; p < np; p++) begin
         if (p > 0) q.push_back(cur);
         while (cur != tgt) begin
            cur += (tgt > cur) ? 1 : -1;
            q.push_back(cur);
         end
         tgt = (p % 2 == 0) ? v.sv : v.ev;
      end
      @(negedge clk);
      start  = 1'b1;
      sval   = W'(v.sv);
      eval   = W'(v.ev);
      passes = PW'(v.np);
      @(posedge clk);
      #1;
      start  = 1'b0;
      sval   = ~W'(v.sv);
      eval   = ~W'(v.ev);
      passes = ~PW'(v.np);
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (v.poke && c == 3) start = 1'b1;
         if (v.poke && c == 4) start = 1'b0;
         if (load) nload++;
         if (en) nen++;
         if (!busy && (load || en || up)) viol++;
         if (load && en) viol++;
         if (c == 2) up_c2 = int'(up);
         if (done_c > 0 && c == done_c + 1 && busy) viol++;
         if (done) begin
            ndone++;
            if (done_c < 0) begin
               done_c = c;
               fin = int'(count_out);
            end
         end
         if (c >= 2 && done_c < 0 && c - 2 < q.size())
            if (int'(count_out) != q[c-2]) errs++;
         if (done_c > 0 && c == done_c + 2) break;
      end
      chk({v.name, "_done_cycle"}, done_c, v.exp_done);
      chk({v.name, "_done_pulses"}, ndone, 1);
      chk({v.name, "_loads"}, nload, 1);
      chk({v.name, "_en_cycles"}, nen, v.exp_en);
      chk({v.name, "_up"}, up_c2, v.exp_up);
      chk({v.name, "_trace_errs"}, errs, 0);
      chk({v.name, "_ctl_viol"}, viol, 0);
      chk({v.name, "_final"}, fin, q[q.size()-1]);
   endtask

   initial begin
      vec_t vecs[5];
      vec_t vafter;
      int   found;
      int   nd;
      int   nb;
      vecs[0] = '{"up3to7", 3, 7, 1, 1'b0, 7, 4, 1};
      vecs[1] = '{"dn15to0", 15, 0, 1, 1'b0, 18, 15, 0};
      vecs[2] = '{"pp2to5x3", 2, 5, 3, 1'b0, 14, 9, 1};
      vecs[3] = '{"eq9p0", 9, 9, 0, 1'b0, 3, 0, 0};
      vecs[4] = '{"poke6to1x2", 6, 1, 2, 1'b1, 14, 10, 0};
      vafter  = '{"after_abort", 4, 6, 1, 1'b0, 5, 2, 1};

      rst    = 1'b1;
      start  = 1'b0;
      abort  = 1'b0;
      sval   = '0;
      eval   = '0;
      passes = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", int'({load, en, up, count_in, busy, done}), 0);
      rst = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Abort mid-count at Count_out == 4 on a 0 -> 10 run.
      @(negedge clk);
      start  = 1'b1;
      sval   = 4'd0;
      eval   = 4'd10;
      passes = 3'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (count_out == 4'd4) begin
            found = 1;
            break;
         end
      end
      chk("abort_reach4", found, 1);
      abort = 1'b1;
      #1;
      chk("abort_en_low", int'(en), 0);
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      nd = 0;
      repeat (4) begin
         @(negedge clk);
         nd += int'(done);
      end
      chk("abort_no_done", nd, 0);
      chk("abort_hold4", int'(count_out), 4);
      run_vec(vafter);

      // Abort in IDLE suppresses Start.
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      chk("idle_abort_busy", int'(busy), 0);
      chk("idle_abort_load", int'(load), 0);

      // Reset mid-COUNT.
      @(negedge clk);
      start  = 1'b1;
      sval   = 4'd1;
      eval   = 4'd12;
      passes = 3'd2;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_mid_busy", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_outs", int'({load, en, up, count_in, busy, done}), 0);
      rst = 1'b0;
      nd = 0;
      nb = 0;
      repeat (6) begin
         @(negedge clk);
         nd += int'(done);
         nb += int'(busy);
      end
      chk("rst_mid_no_done", nd, 0);
      chk("rst_mid_idle", nb, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
